// File: rtl/op_sub_pkg.sv
// op_sub_pkg: shared types and flag/clamp helpers for the serial subtractor
package op_sub_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // Clamp constant for an n-bit two's-complement result: most negative when neg, else most positive
  function automatic logic [63:0] sat_value(input logic neg, input int n);
    return neg ? (64'd1 << (n - 1)) : ((64'd1 << (n - 1)) - 64'd1);
  endfunction
  // Signed overflow of x + y = r from sign bits; returns {ov, uv}. Subtract passes y = ~b
  function automatic logic [1:0] add_flags(input logic x, input logic y, input logic r);
    return {~x & ~y & r, x & y & ~r};
  endfunction
endpackage

// File: rtl/op_sub_digit.sv
// op_sub_digit: one W-bit slice of a - b computed as a + ~b + carry
module op_sub_digit #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_d,
  input  logic [W-1:0] b_d,
  input  logic         cin,
  output logic [W-1:0] diff_d,
  output logic         cout
);
  assign {cout, diff_d} = {1'b0, a_d} + {1'b0, ~b_d} + {{W{1'b0}}, cin};
endmodule

// File: rtl/op_sub_serial.sv
// op_sub_serial: digit-serial a - b, W bits per clock LSB first, with wrap/saturate and ov/uv flags
module op_sub_serial
  import op_sub_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = 2,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ov,
  output logic         uv
);
  localparam int D = (W >= 1) ? N / W : 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [N-1:0] SAT_POS = N'(sat_value(1'b0, N));
  localparam logic [N-1:0] SAT_NEG = N'(sat_value(1'b1, N));

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_param
    $error("op_sub_serial: W must divide N and satisfy 1 <= W <= N");
  end

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] a_sh, b_sh, raw, raw_n, res_n;
  logic a_msb, b_msb, carry, cout, last, ov_n, uv_n;
  logic [W-1:0] diff_d;
  logic [1:0] sflags;

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == CW'(D - 1);

  op_sub_digit #(.W(W)) u_digit (
    .a_d   (a_sh[W-1:0]),
    .b_d   (b_sh[W-1:0]),
    .cin   (carry),
    .diff_d(diff_d),
    .cout  (cout)
  );

  // Next-state: accept in IDLE, one digit per CALC edge, hold DONE until the consumer takes it
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE)
            : state == CALC ? (last ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  // Final result and flags, valid on the edge that processes the last digit
  always_comb begin
    raw_n = (raw >> W) | (N'(diff_d) << (N - W));
    sflags = add_flags(a_msb, ~b_msb, raw_n[N-1]);
    ov_n = SIGNED != 0 ? sflags[1] : 1'b0;
    uv_n = SIGNED != 0 ? sflags[0] : ~cout;
    res_n = (SATURATE != 0 && ov_n) ? SAT_POS
          : (SATURATE != 0 && uv_n) ? (SIGNED != 0 ? SAT_NEG : '0)
          : raw_n;
  end

  // Operand capture, digit shifting, borrow chain and result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      raw <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      ov <= 1'b0;
      uv <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh <= a;
      b_sh <= b;
      a_msb <= a[N-1];
      b_msb <= b[N-1];
      raw <= '0;
      carry <= 1'b1;
      cnt <= '0;
    end else if (state == CALC) begin
      a_sh <= a_sh >> W;
      b_sh <= b_sh >> W;
      raw <= raw_n;
      carry <= cout;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        result <= res_n;
        ov <= ov_n;
        uv <= uv_n;
      end
    end
  end
endmodule
